// File: rtl/fetch_queue.sv
// Multi-slot instruction queue between icache fetch and superscalar decode.
// Optional same-cycle bypass into an empty queue: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int FW    = 2,
  parameter int DW    = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [63:0]                  in_pc,
  input  logic [FW*32-1:0]             in_instr,
  input  logic [$clog2(FW+1)-1:0]      in_cnt,
  output logic [DW-1:0]                out_valid,
  output logic [DW*32-1:0]             out_instr,
  output logic [DW*64-1:0]             out_pc,
  input  logic [$clog2(DW+1)-1:0]      out_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = (DW > FW) ? DW : FW;

  logic [31:0]    mem_instr [DEPTH];
  logic [63:0]    mem_pc    [DEPTH];
  logic [PW-1:0]  rd_q;
  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  occ;
  logic [SW*32-1:0] in_instr_x;

  logic push;
  logic byp;
  int   in_n;
  int   push_n;
  int   avail;
  int   take_n;
  int   skip;
  int   pop_n;

  assign occ        = wr_q - rd_q;
  assign count      = CW'(occ);
  assign in_ready   = (int'(occ) + FW) <= DEPTH;
  assign in_instr_x = (SW*32)'(in_instr);

  always_comb begin
    in_n   = (int'(in_cnt) > FW) ? FW : int'(in_cnt);
    push   = in_valid & in_ready & ~flush;
    push_n = push ? in_n : 0;
    byp    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp    = push && (occ == '0);
`endif
    if (byp)
      avail = (in_n > DW) ? DW : in_n;
    else
      avail = (int'(occ) > DW) ? DW : int'(occ);
    take_n = (int'(out_take) > avail) ? avail : int'(out_take);
    // bypassed slots that decode takes are never written
    skip   = byp ? take_n : 0;
    pop_n  = byp ? 0 : take_n;
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    for (int i = 0; i < DW; i++) begin
      out_valid[i] = (i < avail);
      if (byp) begin
        out_instr[32*i +: 32] = in_instr_x[32*i +: 32];
        out_pc[64*i +: 64]    = in_pc + 64'(4*i);
      end else begin
        out_instr[32*i +: 32] =
          mem_instr[AW'(int'(rd_q[AW-1:0]) + i)];
        out_pc[64*i +: 64] =
          mem_pc[AW'(int'(rd_q[AW-1:0]) + i)];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q <= '0;
      wr_q <= '0;
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_q + PW'(pop_n);
      wr_q <= wr_q + PW'(push_n - skip);
    end
  end

  always_ff @(posedge CLK) begin
    for (int j = 0; j < FW; j++) begin
      if (!RST && push && j >= skip && j < in_n) begin
        mem_instr[AW'(int'(wr_q[AW-1:0]) + j - skip)] <=
          in_instr[32*j +: 32];
        mem_pc[AW'(int'(wr_q[AW-1:0]) + j - skip)] <=
          in_pc + 64'(4*j);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=8, FW=2, DW=2).
// Bypass expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;

  logic         CLK;
  logic         RST;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_pc;
  logic [63:0]  in_instr;
  logic [1:0]   in_cnt;
  logic [1:0]   out_valid;
  logic [63:0]  out_instr;
  logic [127:0] out_pc;
  logic [1:0]   out_take;
  logic [3:0]   count;

  int vectors = 0;
  int miscompares = 0;

  fetch_queue #(.DEPTH(8), .FW(2), .DW(2)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_take(out_take), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ins(input logic [63:0] pc);
    return ~pc[31:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] n,
                     input logic [63:0] pc, input logic [1:0] tk);
    in_valid = v;
    in_cnt   = n;
    in_pc    = pc;
    in_instr = {ins(pc + 64'd4), ins(pc)};
    out_take = tk;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_pair(input string tag,
                          input logic [63:0] pc0,
                          input logic [63:0] pc1);
    chk({tag, "_pc0"}, out_pc[63:0], pc0);
    chk({tag, "_pc1"}, out_pc[127:64], pc1);
    chk({tag, "_in0"}, 64'(out_instr[31:0]), 64'(ins(pc0)));
    chk({tag, "_in1"}, 64'(out_instr[63:32]), 64'(ins(pc1)));
  endtask

  initial begin
    RST = 1'b1;
    flush = 1'b0;
    drv(1'b1, 2'd2, 64'h5000, 2'd0);
    tick;
    tick;
    RST = 1'b0;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);

    // fill with four full beats, nothing taken
    for (int b = 0; b < 4; b++) begin
      drv(1'b1, 2'd2, 64'h8000_0000 + 64'(8*b), 2'd0);
      tick;
      chk("fill_count", 64'(count), 64'(2*(b+1)));
      chk("fill_rdy", 64'(in_ready), (b < 3) ? 64'd1 : 64'd0);
    end
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("full_oval", 64'(out_valid), 64'd3);
    for (int k = 0; k < 4; k++) begin
      chk_pair("drain", 64'h8000_0000 + 64'(8*k),
               64'h8000_0004 + 64'(8*k));
      drv(1'b0, 2'd0, 64'h0, 2'd2);
      tick;
    end
    drv(1'b0, 2'd0, 64'h0, 2'd2);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_oval", 64'(out_valid), 64'd0);
    tick;
    chk("underflow_count", 64'(count), 64'd0);

    // advance pointers to index 5
    drv(1'b1, 2'd2, 64'h100, 2'd0); tick;
    drv(1'b1, 2'd2, 64'h200, 2'd0); tick;
    drv(1'b1, 2'd1, 64'h300, 2'd0); tick;
    drv(1'b0, 2'd0, 64'h0, 2'd2);   tick;
    drv(1'b0, 2'd0, 64'h0, 2'd2);   tick;
    chk("pre_one", 64'(count), 64'd1);
    chk("pre_one_pc", out_pc[63:0], 64'h300);
    drv(1'b0, 2'd0, 64'h0, 2'd1);   tick;

    // partial beat then over-take
    drv(1'b1, 2'd1, 64'h400, 2'd0); tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("part_oval", 64'(out_valid), 64'd1);
    chk("part_pc", out_pc[63:0], 64'h400);
    chk("part_count", 64'(count), 64'd1);
    drv(1'b0, 2'd0, 64'h0, 2'd2);   tick;
    chk("otake_count", 64'(count), 64'd0);

    // rd at index 6: 0x600 beat splits across 7 -> 0
    drv(1'b1, 2'd1, 64'h500, 2'd0); tick;
    drv(1'b1, 2'd2, 64'h600, 2'd0); tick;
    drv(1'b1, 2'd2, 64'h700, 2'd0); tick;
    drv(1'b1, 2'd2, 64'h800, 2'd0); tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("w7_count", 64'(count), 64'd7);
    chk("w7_rdy", 64'(in_ready), 64'd0);
    chk_pair("w7", 64'h500, 64'h600);
    // push refused at count 7 even while popping
    drv(1'b1, 2'd1, 64'hA00, 2'd1); tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("w6_count", 64'(count), 64'd6);
    chk("w6_rdy", 64'(in_ready), 64'd1);
    chk_pair("wrap", 64'h600, 64'h604);
    drv(1'b1, 2'd2, 64'h900, 2'd2); tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("conc_count", 64'(count), 64'd6);
    chk_pair("conc_a", 64'h700, 64'h704);
    drv(1'b0, 2'd0, 64'h0, 2'd2);   tick;
    chk_pair("conc_b", 64'h800, 64'h804);
    drv(1'b0, 2'd0, 64'h0, 2'd2);   tick;
    chk_pair("conc_c", 64'h900, 64'h904);
    drv(1'b0, 2'd0, 64'h0, 2'd2);   tick;
    chk("conc_end", 64'(count), 64'd0);

    // flush with concurrent push and take
    drv(1'b1, 2'd2, 64'hB00, 2'd0); tick;
    drv(1'b1, 2'd2, 64'hC00, 2'd0); tick;
    drv(1'b1, 2'd1, 64'hD00, 2'd0); tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("pre_flush", 64'(count), 64'd5);
    flush = 1'b1;
    drv(1'b1, 2'd2, 64'hE00, 2'd2); tick;
    flush = 1'b0;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_oval", 64'(out_valid), 64'd0);
    chk("flush_rdy", 64'(in_ready), 64'd1);
    drv(1'b1, 2'd2, 64'hF00, 2'd0); tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("postfl_count", 64'(count), 64'd2);
    chk_pair("postfl", 64'hF00, 64'hF04);
    drv(1'b0, 2'd0, 64'h0, 2'd2);   tick;

    // push into empty queue with take=1
    drv(1'b1, 2'd2, 64'h1000, 2'd1);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_oval", 64'(out_valid), 64'd3);
    chk("byp_pc0", out_pc[63:0], 64'h1000);
    tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("byp_count", 64'(count), 64'd1);
    chk("byp_next", out_pc[63:0], 64'h1004);
`else
    chk("nobyp_oval", 64'(out_valid), 64'd0);
    tick;
    drv(1'b0, 2'd0, 64'h0, 2'd0);
    chk("nobyp_count", 64'(count), 64'd2);
    chk("nobyp_pc0", out_pc[63:0], 64'h1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
